// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned PC_W_DEFAULT   = 8;
  localparam int unsigned INST_W_DEFAULT = 9;
  localparam int unsigned CNT_W          = 16;

  // Halt marker is the all-ones instruction word.
  localparam logic [INST_W_DEFAULT-1:0] HALT_INST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating count of fetched instructions. Only built with FETCH_PERF_CNT_EN.
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; stick at all-ones once reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: IDLE/RUN/HALT FSM, stall and branch
// redirect, halt-on-all-ones. Optional macro FETCH_PERF_CNT_EN adds the
// inst_count output backed by fetch_perf_counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEFAULT,
  parameter int unsigned INST_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   inst_address,
  input  logic [INST_W-1:0] inst_in,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              inst_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  inst_count
`endif
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            is_halt;

  // Halt marker is all ones at whatever INST_W this instance uses.
  assign is_halt      = &inst_in;
  // ROM address comes straight from the PC register; redirects land next cycle.
  assign inst_address = pc;

  // Fetch FSM with all outputs registered; stall beats branch, branch beats halt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= '0;
      inst_out   <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc         <= '0;
          inst_valid <= 1'b0;
          halted     <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (!stall) begin
            if (branch_taken) begin
              // Squash the word fetched this cycle (one bubble).
              pc         <= branch_target;
              inst_valid <= 1'b0;
            end else begin
              inst_out   <= inst_in;
              pc_out     <= pc;
              inst_valid <= 1'b1;
              if (is_halt) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
        end
        HALT: begin
          inst_valid <= 1'b0;
          halted     <= 1'b1;
          if (start) begin
            pc     <= '0;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          inst_valid <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic cnt_clear;
  logic cnt_incr;

  // Only an accepted start clears; start during RUN is ignored.
  assign cnt_clear = start && ((state == IDLE) || (state == HALT));
  // Every new fetch that sets inst_valid, including the halt word itself.
  assign cnt_incr  = (state == RUN) && !stall && !branch_taken;

  fetch_perf_counter u_perf_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .incr    (cnt_incr),
    .count   (inst_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] inst_address;
  logic [8:0] inst_in;
  logic [8:0] inst_out;
  logic [7:0] pc_out;
  logic       inst_valid;
  logic       halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] inst_count;
`endif

  logic [8:0] rom [256];
  int n_tests;
  int n_fail;

  assign inst_in = rom[inst_address];

  fetch_unit #(
    .PC_W   (8),
    .INST_W (9)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_address  (inst_address),
    .inst_in       (inst_in),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .inst_count    (inst_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then pulse start; returns with the FSM in RUN at PC 0.
  task automatic reset_start();
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    #3;
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    #3;
    n_tests++; if (inst_out !== 9'h000) begin n_fail++; $display("FAIL reset_inst_out got %h exp 000", inst_out); end
    n_tests++; if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc_out got %h exp 00", pc_out); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted); end
    n_tests++; if (inst_address !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", inst_address); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    // No start: IDLE holds PC 0 and no valid.
    n_tests++; if (inst_valid !== 1'b0 || inst_address !== 8'h00) begin
      n_fail++; $display("FAIL idle_hold got valid=%b addr=%h exp 0/00", inst_valid, inst_address);
    end
  endtask

  task automatic test_run_sequence();
    logic [8:0] exp_inst [3];
    exp_inst[0] = 9'h001; exp_inst[1] = 9'h049; exp_inst[2] = 9'h081;
    reset_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (inst_out !== exp_inst[i] || pc_out !== 8'(i) || inst_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL run_seq[%0d] got inst=%h pc=%h v=%b exp inst=%h pc=%h v=1",
                 i, inst_out, pc_out, inst_valid, exp_inst[i], 8'(i));
      end
    end
    n_tests++; if (inst_address !== 8'h03) begin n_fail++; $display("FAIL run_seq_addr got %h exp 03", inst_address); end
  endtask

  task automatic test_stall();
    reset_start();
    tick(); tick();  // PC=2, inst_out=ROM[1]
    stall = 1'b1;
    branch_taken = 1'b1; branch_target = 8'h50;  // must be ignored while stalled
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (inst_address !== 8'h02 || inst_out !== 9'h049 || pc_out !== 8'h01 || inst_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got addr=%h inst=%h pc=%h v=%b exp 02/049/01/1",
                 i, inst_address, inst_out, pc_out, inst_valid);
      end
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    n_tests++; if (inst_out !== 9'h081 || pc_out !== 8'h02 || inst_address !== 8'h03) begin
      n_fail++; $display("FAIL stall_resume got inst=%h pc=%h addr=%h exp 081/02/03", inst_out, pc_out, inst_address);
    end
  endtask

  // ROM[4] is the halt word here, so the branch also squashes a halt.
  task automatic test_branch();
    reset_start();
    for (int i = 0; i < 4; i++) tick();  // PC=4
    branch_taken = 1'b1; branch_target = 8'h01;
    tick();
    branch_taken = 1'b0;
    n_tests++; if (inst_valid !== 1'b0 || inst_address !== 8'h01 || halted !== 1'b0) begin
      n_fail++; $display("FAIL branch_bubble got v=%b addr=%h h=%b exp 0/01/0", inst_valid, inst_address, halted);
    end
    tick();
    n_tests++; if (inst_out !== 9'h049 || pc_out !== 8'h01 || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL branch_target got inst=%h pc=%h v=%b exp 049/01/1", inst_out, pc_out, inst_valid);
    end
  endtask

  task automatic test_halt();
    reset_start();
    for (int i = 0; i < 4; i++) tick();  // PC=4
    tick();
    n_tests++; if (inst_out !== 9'h1FF || inst_valid !== 1'b1 || pc_out !== 8'h04) begin
      n_fail++; $display("FAIL halt_accept got inst=%h v=%b pc=%h exp 1ff/1/04", inst_out, inst_valid, pc_out);
    end
    tick();
    n_tests++; if (halted !== 1'b1 || inst_valid !== 1'b0 || inst_address !== 8'h04) begin
      n_fail++; $display("FAIL halt_state got h=%b v=%b addr=%h exp 1/0/04", halted, inst_valid, inst_address);
    end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
    tick();
    n_tests++; if (halted !== 1'b1 || inst_address !== 8'h04) begin
      n_fail++; $display("FAIL halt_frozen got h=%b addr=%h exp 1/04", halted, inst_address);
    end
    stall = 1'b0; branch_taken = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (halted !== 1'b0 || inst_address !== 8'h00) begin
      n_fail++; $display("FAIL halt_restart got h=%b addr=%h exp 0/00", halted, inst_address);
    end
    tick();
    n_tests++; if (inst_out !== 9'h001 || inst_valid !== 1'b1 || pc_out !== 8'h00) begin
      n_fail++; $display("FAIL halt_refetch got inst=%h v=%b pc=%h exp 001/1/00", inst_out, inst_valid, pc_out);
    end
  endtask

  task automatic test_wrap();
    reset_start();
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    n_tests++; if (inst_address !== 8'hFF) begin n_fail++; $display("FAIL wrap_branch got %h exp ff", inst_address); end
    tick();
    n_tests++; if (inst_address !== 8'h00 || pc_out !== 8'hFF || inst_out !== 9'h0FF || inst_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap got addr=%h pc=%h inst=%h v=%b exp 00/ff/0ff/1",
                         inst_address, pc_out, inst_out, inst_valid);
    end
  endtask

  task automatic test_async_reset();
    reset_start();
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;  // between edges: no clock involved
    n_tests++; if (inst_out !== 9'h000 || pc_out !== 8'h00 || inst_valid !== 1'b0 ||
                   inst_address !== 8'h00 || halted !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got inst=%h pc=%h v=%b addr=%h h=%b exp all 0",
                         inst_out, pc_out, inst_valid, inst_address, halted);
    end
`ifdef FETCH_PERF_CNT_EN
    n_tests++; if (inst_count !== 16'd0) begin n_fail++; $display("FAIL count_reset got %0d exp 0", inst_count); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL no_residual got v=%b exp 0", inst_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (inst_valid !== 1'b1 || pc_out !== 8'h02 || inst_out !== 9'h081) begin
      n_fail++; $display("FAIL post_reset_run got v=%b pc=%h inst=%h exp 1/02/081", inst_valid, pc_out, inst_out);
    end
`ifdef FETCH_PERF_CNT_EN
    n_tests++; if (inst_count !== 16'd3) begin n_fail++; $display("FAIL count_three got %0d exp 3", inst_count); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) rom[i] = {1'b0, 8'(i)};
    rom[0] = 9'h001; rom[1] = 9'h049; rom[2] = 9'h081; rom[4] = 9'h1FF;
    test_reset();
    test_run_sequence();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, width of program counter and instruction address.
REQ-002 Parameter INST_W, default 9, width of an instruction word.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle pulse; begins execution at address 0.
REQ-006 Port stall  input  1  downstream not ready; freeze fetch state.
REQ-007 Port branch_taken  input  1  decode stage redirects PC this cycle.
REQ-008 Port branch_target  input  PC_W  absolute redirect address.
REQ-009 Port inst_address  output  PC_W  current PC, drives instruction ROM address.
REQ-010 Port inst_in  input  INST_W  ROM data, combinational from inst_address.
REQ-011 Port inst_out  output  INST_W  registered instruction to decode.
REQ-012 Port pc_out  output  PC_W  address inst_out was fetched from.
REQ-013 Port inst_valid  output  1  inst_out holds a live instruction.
REQ-014 Port halted  output  1  high while in HALT state.

Function
REQ-015 FSM states IDLE, RUN, HALT; IDLE on reset.
REQ-016 IDLE: PC held at 0, inst_valid 0; start -> RUN next edge.
REQ-017 RUN, stall low: inst_out<=inst_in, pc_out<=PC, inst_valid<=1, PC<=PC+1 -- one-cycle address-to-inst_out latency.
REQ-018 PC increment wraps modulo 2**PC_W (all-ones -> 0), no flag.
REQ-019 RUN, stall high: PC, inst_out, pc_out, inst_valid, state all hold; branch_taken ignored.
REQ-020 RUN, stall low, branch_taken high: PC<=branch_target, inst_valid<=0 (one-bubble squash of the word fetched this cycle).
REQ-021 Stall has priority over branch; decode holds branch_taken until stall drops.
REQ-022 inst_in equal to HALT_INST (all ones) accepted in RUN (stall low, no branch): latched with inst_valid 1, state -> HALT, PC not incremented.
REQ-023 Branch and HALT_INST same cycle: branch wins, halt squashed, stay in RUN.
REQ-024 HALT: halted 1, inst_valid 0 from first HALT cycle, PC frozen; stall/branch ignored.
REQ-025 start in HALT -> PC=0, state RUN next edge; start in RUN ignored.
REQ-026 inst_address equals PC register directly (no combinational redirect path).

Reset
REQ-027 reset_n low asynchronously forces: state IDLE, PC 0, inst_out 0, pc_out 0, inst_valid 0, halted 0.
REQ-028 Reset mid-RUN or mid-stall discards in-flight instruction; no residual valid after release.
REQ-029 First rising edge after reset_n release may accept start.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: add output inst_count (16 bits) counting each cycle inst_valid is set by a new fetch; saturates at 16'hFFFF; cleared by reset and by start.
REQ-031 Macro undefined: no inst_count port, no counter logic; all other behaviour identical.

Structure
REQ-032 Package fetch_pkg holds PC_W/INST_W defaults, HALT_INST constant, and the fetch_state_t enum (IDLE, RUN, HALT).
REQ-033 Counter under FETCH_PERF_CNT_EN is sub-module fetch_perf_counter; no other sub-modules.

Verification
REQ-034 Reset, start, ROM {0:9'h001,1:9'h049,2:9'h081} no stall -> inst_out 9'h001,9'h049,9'h081 on cycles 1,2,3 with pc_out 0,1,2, inst_valid 1.
REQ-035 stall high 3 cycles at PC=2 -> inst_address, inst_out, pc_out, inst_valid unchanged all 3 cycles; resumes at PC 3.
REQ-036 branch_taken with target 8'h01 at PC=4 -> next cycle inst_valid 0, inst_address 1; following cycle inst_out=ROM[1], pc_out 1.
REQ-037 ROM[4]=9'h1FF -> inst_out 9'h1FF valid one cycle, then halted 1, inst_valid 0, inst_address frozen at 4; start -> PC 0, RUN.
REQ-038 PC=8'hFF, no branch -> next inst_address 8'h00, pc_out 8'hFF.
REQ-039 reset_n low mid-RUN between edges -> outputs zero immediately; FETCH_PERF_CNT_EN build: inst_count 0, then 3 after three fetches.
